// File: rtl/fifo_ms_merge_pkg.sv
// Shared types and width helpers for the multi-stream merge FIFO.
package fifo_ms_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned FLUX_DEF  = 2;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef logic [ptr_w(FLUX_DEF)-1:0] flux_idx_t;

  localparam int unsigned CNT_W = ptr_w(DEPTH_DEF) + 1;

endpackage

// File: rtl/fifo_ms_merge_if.sv
// Per-flux write side plus serial output handshake of the merge FIFO.
interface fifo_ms_merge_if
  import fifo_ms_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned FLUX  = FLUX_DEF
);

  logic [FLUX-1:0]       wr;
  logic [FLUX*WIDTH-1:0] datain;
  logic [FLUX-1:0]       full;
  logic                  out_write;
  logic [WIDTH-1:0]      out_dataout;
  logic                  out_full;

  modport master (
    output wr, datain, out_full,
    input  full, out_write, out_dataout
  );

  modport slave (
    input  wr, datain, out_full,
    output full, out_write, out_dataout
  );

endinterface

// File: rtl/fifo_ms_merge_lane.sv
// Single-flux circular buffer; writes to a full queue are dropped.
module fifo_ms_lane
  import fifo_ms_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned PW   = ptr_w(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rp_q];

  // full is judged on the pre-edge count, so a same-edge pop never frees room.
  assign push = wr & ~full;
  assign pop  = rd & ~empty;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wp_q] = din;
      wp_d        = wp_q + PW'(1);
    end
    if (pop) begin
      rp_d = rp_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_ms_merge.sv
// Merges FLUX per-flux queues onto one registered output in rotating flux order.
// Define FIFO_MS_MERGE_SKIP_EN for work-conserving round robin that skips empty fluxes.
module fifo_ms_merge
  import fifo_ms_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned FLUX  = FLUX_DEF
) (
  input  logic           ck,
  input  logic           rst,
  fifo_ms_merge_if.slave io
);

  localparam int unsigned FW = ptr_w(FLUX);
  localparam int unsigned CW = ptr_w(DEPTH) + 1;

  logic [FLUX-1:0]  lane_full;
  logic [FLUX-1:0]  lane_empty;
  logic [CW-1:0]    lane_cnt  [FLUX];
  logic [WIDTH-1:0] lane_dout [FLUX];
  logic [FLUX-1:0]  avail;
  logic [FLUX-1:0]  rd_c;

  logic [FW-1:0]    cur_flux_q, cur_flux_d;
  logic             out_write_q, out_write_d;
  logic [WIDTH-1:0] out_dataout_q, out_dataout_d;

  logic [FW-1:0]    sel;
  logic             found;
  logic             pop_c;

  for (genvar f = 0; f < FLUX; f++) begin : g_lane
    fifo_ms_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_lane (
      .ck    (ck),
      .rst   (rst),
      .wr    (io.wr[f]),
      .din   (io.datain[f*WIDTH +: WIDTH]),
      .rd    (rd_c[f]),
      .full  (lane_full[f]),
      .empty (lane_empty[f]),
      .count (lane_cnt[f]),
      .dout  (lane_dout[f])
    );

    // empty and count must agree for every lane.
    a_empty_cnt: assert property (@(posedge ck) disable iff (!rst)
      lane_empty[f] == (lane_cnt[f] == '0));
  end

  assign avail = ~lane_empty;

  // Flux selection, pop decision and next-state of selector/output register.
  always_comb begin
    sel           = cur_flux_q;
    found         = 1'b0;
    rd_c          = '0;
    cur_flux_d    = cur_flux_q;
    out_dataout_d = out_dataout_q;
`ifdef FIFO_MS_MERGE_SKIP_EN
    for (int unsigned i = 0; i < FLUX; i++) begin
      logic [FW-1:0] idx;
      idx = FW'((32'(cur_flux_q) + i) % FLUX);
      if (!found && avail[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
`else
    found = avail[cur_flux_q];
`endif
    pop_c       = found & ~io.out_full;
    out_write_d = pop_c;
    if (pop_c) begin
      out_dataout_d = lane_dout[sel];
      cur_flux_d    = (sel == FW'(FLUX - 1)) ? '0 : sel + FW'(1);
    end
    for (int f = 0; f < FLUX; f++) begin
      rd_c[f] = pop_c & (sel == FW'(f));
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      cur_flux_q    <= '0;
      out_write_q   <= 1'b0;
      out_dataout_q <= '0;
    end else begin
      cur_flux_q    <= cur_flux_d;
      out_write_q   <= out_write_d;
      out_dataout_q <= out_dataout_d;
    end
  end

  assign io.full        = lane_full;
  assign io.out_write   = out_write_q;
  assign io.out_dataout = out_dataout_q;

endmodule
